// File: rtl/assoc_hashmap.sv
// assoc_hashmap: set-associative key/value cache with round-robin eviction and a registered lookup.
// Defining HASHMAP_BYPASS_EN forwards same-cycle writes/deletes to the read result.
module assoc_hashmap #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int NUM_SETS    = 4,
  parameter int NUM_WAYS    = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear_cache,
  input  logic                                     write_request,
  input  logic [KEY_WIDTH-1:0]                     write_key,
  input  logic [VALUE_WIDTH-1:0]                   write_value,
  input  logic                                     delete_request,
  input  logic [KEY_WIDTH-1:0]                     delete_key,
  input  logic                                     read_request,
  input  logic [KEY_WIDTH-1:0]                     read_key,
  output logic                                     read_valid,
  output logic                                     read_hit,
  output logic [VALUE_WIDTH-1:0]                   read_value,
  output logic                                     evict_valid,
  output logic [KEY_WIDTH-1:0]                     evict_key,
  output logic [VALUE_WIDTH-1:0]                   evict_value,
  output logic [$clog2(NUM_SETS*NUM_WAYS+1)-1:0]   count
);
  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int CW = $clog2(NUM_SETS*NUM_WAYS+1);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]                  valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][KEY_WIDTH-1:0]   key_q, key_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][VALUE_WIDTH-1:0] val_q, val_d;
  logic [NUM_SETS-1:0][WW-1:0]                        ptr_q, ptr_d;
  logic [CW-1:0]                                      count_q, count_d;
  logic                   read_valid_q, read_valid_d, read_hit_q, read_hit_d;
  logic [VALUE_WIDTH-1:0] read_value_q, read_value_d;
  logic                   evict_valid_q, evict_valid_d;
  logic [KEY_WIDTH-1:0]   evict_key_q, evict_key_d;
  logic [VALUE_WIDTH-1:0] evict_value_q, evict_value_d;

  logic [SW-1:0]          ws, ds, rs;
  logic [WW-1:0]          w_way, f_way, d_way, tgt;
  logic                   w_hit, w_free, d_hit, r_hit, same, do_del, full, victim_del;
  logic [VALUE_WIDTH-1:0] r_val;

  always_comb begin
    ws = write_key[SW-1:0];
    ds = delete_key[SW-1:0];
    rs = read_key[SW-1:0];
    w_hit = 1'b0;
    w_way = '0;
    w_free = 1'b0;
    f_way = '0;
    d_hit = 1'b0;
    d_way = '0;
    r_hit = 1'b0;
    r_val = '0;
    // Descending scan so the lowest-index free way wins
    for (int i = NUM_WAYS-1; i >= 0; i--) begin
      if (valid_q[ws][i] && key_q[ws][i] == write_key) begin
        w_hit = 1'b1;
        w_way = WW'(i);
      end
      if (!valid_q[ws][i]) begin
        w_free = 1'b1;
        f_way = WW'(i);
      end
      if (valid_q[ds][i] && key_q[ds][i] == delete_key) begin
        d_hit = 1'b1;
        d_way = WW'(i);
      end
      if (valid_q[rs][i] && key_q[rs][i] == read_key) begin
        r_hit = 1'b1;
        r_val = val_q[rs][i];
      end
    end
    same = write_request && delete_request && write_key == delete_key;
    do_del = delete_request && d_hit && !same;
    full = write_request && !w_hit && !w_free;
    victim_del = full && do_del && ds == ws && d_way == ptr_q[ws];
    tgt = w_hit ? w_way : w_free ? f_way : ptr_q[ws];
    valid_d = valid_q;
    key_d = key_q;
    val_d = val_q;
    ptr_d = ptr_q;
    evict_valid_d = full && !victim_del;
    evict_key_d = key_q[ws][ptr_q[ws]];
    evict_value_d = val_q[ws][ptr_q[ws]];
    if (do_del) valid_d[ds][d_way] = 1'b0;
    if (write_request) begin
      valid_d[ws][tgt] = 1'b1;
      key_d[ws][tgt] = write_key;
      val_d[ws][tgt] = write_value;
    end
    if (full) ptr_d[ws] = (ptr_q[ws] == WW'(NUM_WAYS-1)) ? '0 : ptr_q[ws] + WW'(1);
    count_d = count_q + CW'(write_request && !w_hit && w_free) - CW'(do_del && !victim_del);
    read_valid_d = read_request;
`ifdef HASHMAP_BYPASS_EN
    read_hit_d = (write_request && write_key == read_key) ||
                 (r_hit && !(do_del && delete_key == read_key));
    read_value_d = (write_request && write_key == read_key) ? write_value :
                   read_hit_d ? r_val : '0;
`else
    read_hit_d = r_hit;
    read_value_d = r_val;
`endif
    if (clear_cache) begin
      valid_d = '0;
      ptr_d = '0;
      count_d = '0;
      evict_valid_d = 1'b0;
      read_hit_d = 1'b0;
      read_value_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
    val_q <= val_d;
    evict_key_q <= evict_key_d;
    evict_value_q <= evict_value_d;
    if (rst) begin
      valid_q <= '0;
      ptr_q <= '0;
      count_q <= '0;
      read_valid_q <= 1'b0;
      read_hit_q <= 1'b0;
      read_value_q <= '0;
      evict_valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
      read_valid_q <= read_valid_d;
      read_hit_q <= read_hit_d;
      read_value_q <= read_value_d;
      evict_valid_q <= evict_valid_d;
    end
  end

  assign read_valid = read_valid_q;
  assign read_hit = read_hit_q;
  assign read_value = read_value_q;
  assign evict_valid = evict_valid_q;
  assign evict_key = evict_key_q;
  assign evict_value = evict_value_q;
  assign count = count_q;
endmodule

// File: tb/tb_assoc_hashmap.sv
// tb_assoc_hashmap: scoreboard bench for assoc_hashmap against a behavioural cache model.
module tb_assoc_hashmap;
  localparam int NS = 4;
  localparam int NW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, clear_cache = 1'b0;
  logic       write_request = 1'b0, delete_request = 1'b0, read_request = 1'b0;
  logic [7:0] write_key = '0, write_value = '0, delete_key = '0, read_key = '0;
  logic       read_valid, read_hit, evict_valid;
  logic [7:0] read_value, evict_key, evict_value;
  logic [3:0] count;

  always #5 clk = ~clk;

  assoc_hashmap #(.KEY_WIDTH(8), .VALUE_WIDTH(8), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst), .clear_cache(clear_cache),
    .write_request(write_request), .write_key(write_key), .write_value(write_value),
    .delete_request(delete_request), .delete_key(delete_key),
    .read_request(read_request), .read_key(read_key),
    .read_valid(read_valid), .read_hit(read_hit), .read_value(read_value),
    .evict_valid(evict_valid), .evict_key(evict_key), .evict_value(evict_value),
    .count(count)
  );

  typedef struct { int tag; logic hit; logic [7:0] v; } rd_t;
  typedef struct { int tag; logic [7:0] k; logic [7:0] v; } ev_t;
  rd_t rq[$];
  ev_t eq[$];
  int edge_cnt = 0, checks = 0, passes = 0, exp_count = 0;

  bit         mv[NS][NW];
  logic [7:0] mk[NS][NW], mval[NS][NW];
  int         mp[NS];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", n, a, e, edge_cnt);
  endtask

  function automatic int find(int s, logic [7:0] k);
    for (int w = 0; w < NW; w++) if (mv[s][w] && mk[s][w] == k) return w;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    rd_t e;
    ev_t x;
    bit er, ee;
    edge_cnt++;
    #2;
    er = rq.size() > 0 && rq[0].tag == edge_cnt;
    chk("read_valid", {31'b0, read_valid}, {31'b0, er});
    if (er) begin
      e = rq.pop_front();
      if (read_valid) begin
        chk("read_hit", {31'b0, read_hit}, {31'b0, e.hit});
        chk("read_value", {24'b0, read_value}, {24'b0, e.v});
      end
    end
    ee = eq.size() > 0 && eq[0].tag == edge_cnt;
    chk("evict_valid", {31'b0, evict_valid}, {31'b0, ee});
    if (ee) begin
      x = eq.pop_front();
      if (evict_valid) begin
        chk("evict_key", {24'b0, evict_key}, {24'b0, x.k});
        chk("evict_value", {24'b0, evict_value}, {24'b0, x.v});
      end
    end
    chk("count", {28'b0, count}, exp_count);
  end

  task automatic step(bit w, logic [7:0] wk, logic [7:0] wv, bit d, logic [7:0] dk,
                      bit r, logic [7:0] rk, bit c, bit rs);
    int ws, ds, rsx, wwy, dwy, rwy, tgt;
    bit same, dodel;
    logic hit;
    logic [7:0] rv;
    @(negedge clk);
    rst = rs; clear_cache = c;
    write_request = w; write_key = wk; write_value = wv;
    delete_request = d; delete_key = dk;
    read_request = r; read_key = rk;
    if (rs) model_clear();
    else if (c) begin
      model_clear();
      if (r) rq.push_back('{tag: edge_cnt + 1, hit: 1'b0, v: 8'h00});
    end else begin
      ws = wk % NS; ds = dk % NS; rsx = rk % NS;
      wwy = find(ws, wk); dwy = find(ds, dk); rwy = find(rsx, rk);
      same = w && d && wk == dk;
      dodel = d && dwy >= 0 && !same;
      hit = rwy >= 0;
      rv = hit ? mval[rsx][rwy] : 8'h00;
`ifdef HASHMAP_BYPASS_EN
      if (dodel && dk == rk) begin hit = 1'b0; rv = 8'h00; end
      if (w && wk == rk) begin hit = 1'b1; rv = wv; end
`endif
      if (r) rq.push_back('{tag: edge_cnt + 1, hit: hit, v: rv});
      tgt = wwy;
      if (w && tgt < 0) begin
        for (int i = 0; i < NW; i++) if (!mv[ws][i] && tgt < 0) tgt = i;
        if (tgt < 0) begin
          tgt = mp[ws];
          mp[ws] = (mp[ws] + 1) % NW;
          if (!(dodel && ds == ws && dwy == tgt))
            eq.push_back('{tag: edge_cnt + 1, k: mk[ws][tgt], v: mval[ws][tgt]});
        end
      end
      if (dodel) mv[ds][dwy] = 1'b0;
      if (w) begin mv[ws][tgt] = 1'b1; mk[ws][tgt] = wk; mval[ws][tgt] = wv; end
    end
    exp_count = 0;
    for (int s = 0; s < NS; s++) for (int i = 0; i < NW; i++) exp_count += int'(mv[s][i]);
  endtask

  task automatic wr(logic [7:0] k, logic [7:0] v); step(1, k, v, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd(logic [7:0] k); step(0, 0, 0, 0, 0, 1, k, 0, 0); endtask
  task automatic dl(logic [7:0] k); step(0, 0, 0, 1, k, 0, 0, 0, 0); endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic clr(); step(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

  initial begin
    model_clear();
    step(0, 0, 0, 0, 0, 1, 8'h05, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(8'h05, 8'hA1); rd(8'h05); idle();
    clr();
    wr(8'h01, 8'h11); wr(8'h05, 8'h55); wr(8'h09, 8'h99); rd(8'h01); rd(8'h09);
    wr(8'h05, 8'hB2); rd(8'h05);
    dl(8'h05); rd(8'h05); dl(8'h0D); idle();
    clr();
    step(1, 8'h22, 8'h33, 0, 0, 1, 8'h22, 0, 0); rd(8'h22);
    wr(8'h0A, 8'h01); wr(8'h0E, 8'h02);
    step(1, 8'h12, 8'h03, 1, 8'h0A, 1, 8'h0A, 0, 0);
    step(1, 8'h16, 8'h04, 1, 8'h12, 0, 0, 0, 0);
    rd(8'h12); rd(8'h16);
    clr();
    for (int i = 0; i < 8; i++) wr(8'(i), 8'(8'h40 + i));
    step(0, 0, 0, 0, 0, 1, 8'h03, 1, 0);
    for (int i = 0; i < 8; i++) rd(8'(i));
    wr(8'h07, 8'h77); rd(8'h07);
    step(0, 0, 0, 0, 0, 1, 8'h07, 0, 1);
    idle();
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 9) < 3, 8'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7, 8'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1);
    end
    idle(); idle(); idle();
    chk("read_queue_drained", rq.size(), 0);
    chk("evict_queue_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
